// File: rtl/piso_serial_tx.sv
// piso_serial_tx: MSB-first parallel-to-serial transmitter with a valid/ready word input.
// Define PISO_PARITY_EN to append an even-parity bit after the LSB of every frame.
module piso_serial_tx #(
    parameter int   WIDTH      = 8,
    parameter logic IDLE_LEVEL = 1'b1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] din,
    input  logic             din_valid,
    output logic             din_ready,
    output logic             sout,
    output logic             sout_valid,
    output logic             frame_start,
    output logic             busy
);
    localparam int CW = $clog2(WIDTH);
`ifdef PISO_PARITY_EN
    typedef enum logic [1:0] {IDLE, SHIFT, PARITY} state_t;
`else
    typedef enum logic {IDLE, SHIFT} state_t;
`endif
    // Declaration initialisers give the idle line level from power-up, before any reset.
    state_t           state   = IDLE;
    logic [WIDTH-2:0] sreg    = '0;
    logic [CW-1:0]    cnt     = '0;
    logic             sout_q  = IDLE_LEVEL;
    logic             valid_q = 1'b0;
    logic             fs_q    = 1'b0;
    logic             last;
    logic             accept;
`ifdef PISO_PARITY_EN
    logic             par_q   = 1'b0;
    assign last = state == PARITY;
`else
    assign last = state == SHIFT && cnt == '0;
`endif
    assign din_ready   = !rst && (state == IDLE || last);
    assign accept      = din_valid && din_ready;
    assign sout        = sout_q;
    assign sout_valid  = valid_q;
    assign frame_start = fs_q;
    assign busy        = valid_q;
    // sreg holds only the bits still to be sent; the current bit lives in sout_q.
    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            sreg    <= '0;
            cnt     <= '0;
            sout_q  <= IDLE_LEVEL;
            valid_q <= 1'b0;
            fs_q    <= 1'b0;
`ifdef PISO_PARITY_EN
            par_q   <= 1'b0;
`endif
        end else if (accept) begin
            state   <= SHIFT;
            sreg    <= din[WIDTH-2:0];
            cnt     <= CW'(WIDTH - 1);
            sout_q  <= din[WIDTH-1];
            valid_q <= 1'b1;
            fs_q    <= 1'b1;
`ifdef PISO_PARITY_EN
            par_q   <= ^din;
`endif
        end else if (state == SHIFT && cnt != '0) begin
            sreg   <= sreg << 1;
            cnt    <= cnt - CW'(1);
            sout_q <= sreg[WIDTH-2];
            fs_q   <= 1'b0;
`ifdef PISO_PARITY_EN
        end else if (state == SHIFT) begin
            state  <= PARITY;
            sout_q <= par_q;
            fs_q   <= 1'b0;
`endif
        end else begin
            state   <= IDLE;
            sout_q  <= IDLE_LEVEL;
            valid_q <= 1'b0;
            fs_q    <= 1'b0;
        end
    end
endmodule

// File: tb/tb_piso_serial_tx.sv
// tb_piso_serial_tx: randomized bench against a bit-queue model of the transmitter.
module tb_piso_serial_tx;
    localparam int W = 8;
    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic [W-1:0] din = '0;
    logic         din_valid = 1'b0;
    logic         din_ready, sout, sout_valid, frame_start, busy;
    int           checks = 0;
    int           errors = 0;
    // Each entry is {frame_start, bit}; q[0] is what should be on the line now.
    logic [1:0]   q[$];

    piso_serial_tx #(.WIDTH(W), .IDLE_LEVEL(1'b1)) dut (
        .clk(clk), .rst(rst), .din(din), .din_valid(din_valid), .din_ready(din_ready),
        .sout(sout), .sout_valid(sout_valid), .frame_start(frame_start), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic check_line();
        check("sout", sout, q.size() != 0 ? q[0][0] : 1'b1);
        check("sout_valid", sout_valid, q.size() != 0);
        check("busy", busy, q.size() != 0);
        check("frame_start", frame_start, q.size() != 0 ? q[0][1] : 1'b0);
    endtask

    task automatic step(input logic r, input logic v, input logic [W-1:0] d);
        logic acc;
        rst = r;
        din_valid = v;
        din = d;
        #1;
        check("din_ready", din_ready, !r && q.size() <= 1);
        acc = v && !r && q.size() <= 1;
        @(posedge clk);
        if (r) q.delete();
        else begin
            if (q.size() != 0) void'(q.pop_front());
            if (acc) begin
                for (int k = W - 1; k >= 0; k--) q.push_back({k == W - 1, d[k]});
`ifdef PISO_PARITY_EN
                q.push_back({1'b0, ^d});
`endif
            end
        end
        #1;
        check_line();
    endtask

    initial begin
        #1;
        check_line();
        @(negedge clk);
        repeat (2) step(1'b1, 1'b0, '0);
        repeat (3) step(1'b0, 1'b0, '0);
        step(1'b0, 1'b1, 8'hA5);
        repeat (10) step(1'b0, 1'b0, 8'h3C);
        step(1'b0, 1'b1, 8'hF0);
        repeat (8) step(1'b0, 1'b1, 8'h0F);
        repeat (10) step(1'b0, 1'b0, '0);
        step(1'b0, 1'b1, 8'h07);
        repeat (11) step(1'b0, 1'b0, '0);
        step(1'b0, 1'b1, 8'hFF);
        repeat (3) step(1'b0, 1'b0, '0);
        step(1'b1, 1'b1, 8'h55);
        step(1'b0, 1'b1, 8'h81);
        repeat (10) step(1'b0, 1'b0, '0);
        repeat (30) step(1'b0, 1'b1, W'($urandom));
        for (int i = 0; i < 600; i++)
            step($urandom_range(39) == 0, $urandom_range(1) == 1, W'($urandom));
        repeat (12) step(1'b0, 1'b0, '0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
